// File: rtl/addr_trace_gen.sv
// Purpose: programmable address stream source (SEQ / LOOP working-set / RAND) for cache stimulus.
// Latency: first address valid 1 cycle after accepted start; one address per cycle when addr_ready=1.
// Backpressure: address and addr_valid hold while addr_ready=0; issued counts only accepted transfers.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   start, mode, base_addr,    run request and configuration; sampled only when idle
//   stride, ws_size, num_access
//   addr_ready                 consumer accepts the presented address this cycle
//   address, addr_valid        presented address and its valid flag
//   busy, done, issued         run in progress, end-of-run pulse, accepted count
module addr_trace_gen #(
    parameter int          ADDR_W    = 32,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] LFSR_SEED = 32'hACE12468
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [CNT_W-1:0]  ws_size,
    input  logic [CNT_W-1:0]  num_access,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] address,
    output logic              addr_valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  issued
);

    localparam logic [31:0] LFSR_POLY = 32'h80200003;
    localparam logic [1:0]  MODE_LOOP = 2'd1;
    localparam logic [1:0]  MODE_RAND = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Galois LFSR, right-shifting: taps are folded in when the bit shifted out is 1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    // Random addresses are word aligned: the two low LFSR bits are dropped.
    function automatic logic [ADDR_W-1:0] rand_addr(input logic [ADDR_W-1:0] b,
                                                   input logic [31:0] l);
        return b ^ ADDR_W'({l[31:2], 2'b00});
    endfunction

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [CNT_W-1:0]    ws_q, ws_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [31:0]         lfsr_q, lfsr_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic                addr_valid_q, addr_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    issued_q, issued_d;

    logic [31:0]         lfsr_nxt;
    logic [CNT_W-1:0]    issued_inc;
    logic [CNT_W-1:0]    idx_inc;
    logic [CNT_W-1:0]    ws_eff;
    logic                xfer;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        base_d       = base_q;
        stride_d     = stride_q;
        ws_d         = ws_q;
        num_d        = num_q;
        idx_d        = idx_q;
        lfsr_d       = lfsr_q;
        address_d    = address_q;
        addr_valid_d = addr_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        issued_d     = issued_q;

        lfsr_nxt     = lfsr_step(lfsr_q);
        issued_inc   = issued_q + CNT_W'(1);
        idx_inc      = idx_q + CNT_W'(1);
        // A zero-length working set behaves as a single-entry loop.
        ws_eff       = (ws_q == '0) ? CNT_W'(1) : ws_q;
        xfer         = addr_valid_q & addr_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    base_d   = base_addr;
                    stride_d = stride;
                    ws_d     = ws_size;
                    num_d    = num_access;
                    issued_d = '0;
                    idx_d    = '0;
                    if (num_access == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = S_RUN;
                        addr_valid_d = 1'b1;
                        busy_d       = 1'b1;
                        if (mode == MODE_RAND) begin
                            lfsr_d    = lfsr_nxt;
                            address_d = rand_addr(base_addr, lfsr_nxt);
                        end else begin
                            address_d = base_addr;
                        end
                    end
                end
            end

            S_RUN: begin
                if (xfer) begin
                    issued_d = issued_inc;
                    if (issued_inc == num_q) begin
                        // Last access accepted: the LFSR is left untouched so the
                        // next run continues from the last address actually used.
                        state_d      = S_DONE;
                        addr_valid_d = 1'b0;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        case (mode_q)
                            MODE_LOOP: begin
                                if (idx_inc == ws_eff) begin
                                    idx_d     = '0;
                                    address_d = base_q;
                                end else begin
                                    idx_d     = idx_inc;
                                    address_d = address_q + stride_q;
                                end
                            end
                            MODE_RAND: begin
                                lfsr_d    = lfsr_nxt;
                                address_d = rand_addr(base_q, lfsr_nxt);
                            end
                            default: address_d = address_q + stride_q;
                        endcase
                    end
                end
            end

            S_DONE: begin
                state_d      = S_IDLE;
                addr_valid_d = 1'b0;
                busy_d       = 1'b0;
            end

            default: begin
                state_d      = S_IDLE;
                addr_valid_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            base_q       <= '0;
            stride_q     <= '0;
            ws_q         <= '0;
            num_q        <= '0;
            idx_q        <= '0;
            lfsr_q       <= LFSR_SEED;
            address_q    <= '0;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            issued_q     <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            base_q       <= base_d;
            stride_q     <= stride_d;
            ws_q         <= ws_d;
            num_q        <= num_d;
            idx_q        <= idx_d;
            lfsr_q       <= lfsr_d;
            address_q    <= address_d;
            addr_valid_q <= addr_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            issued_q     <= issued_d;
        end
    end

    assign address    = address_q;
    assign addr_valid = addr_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign issued     = issued_q;

endmodule

// File: tb/tb_addr_trace_gen.sv
// Purpose: directed scoreboard bench for addr_trace_gen (SEQ, LOOP, wrap, RAND, n=0, reset).
// Latency: expects first address 1 cycle after start and one transfer per cycle with ready high.
// Backpressure: drops addr_ready for a few cycles on a chosen access and checks the hold.
module tb_addr_trace_gen;

    localparam logic [31:0] SEED = 32'hACE12468;
    localparam logic [31:0] POLY = 32'h80200003;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] base_addr;
    logic [31:0] stride;
    logic [15:0] ws_size;
    logic [15:0] num_access;
    logic        addr_ready;
    logic [31:0] address;
    logic        addr_valid;
    logic        busy;
    logic        done;
    logic [15:0] issued;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic [31:0] ref_q[$];
    logic [31:0] tb_lfsr;
    int          stall_at;
    int          stall_left;

    always #5 clk = ~clk;

    addr_trace_gen #(
        .ADDR_W   (32),
        .CNT_W    (16),
        .LFSR_SEED(SEED)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .base_addr  (base_addr),
        .stride     (stride),
        .ws_size    (ws_size),
        .num_access (num_access),
        .addr_ready (addr_ready),
        .address    (address),
        .addr_valid (addr_valid),
        .busy       (busy),
        .done       (done),
        .issued     (issued)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
        tb_lfsr = SEED;
        tick();
    endtask

    // Start one run, scoreboard every accepted address, then check the done pulse.
    task automatic do_run(input logic [1:0] m, input logic [31:0] b, input logic [31:0] s,
                          input logic [15:0] ws, input logic [15:0] n, input bit use_model);
        logic [15:0] wse;
        int          got;
        int          cyc;
        int          stalls;
        wse    = (ws == 16'd0) ? 16'd1 : ws;
        stalls = stall_left;
        exp_q.delete();
        obs_q.delete();
        if (use_model) begin
            for (int k = 0; k < int'(n); k++) begin
                if (m == 2'd2) begin
                    tb_lfsr = lfsr_step(tb_lfsr);
                    exp_q.push_back(b ^ {tb_lfsr[31:2], 2'b00});
                end else if (m == 2'd1) begin
                    exp_q.push_back(b + 32'(k % int'(wse)) * s);
                end else begin
                    exp_q.push_back(b + 32'(k) * s);
                end
            end
        end
        mode       = m;
        base_addr  = b;
        stride     = s;
        ws_size    = ws;
        num_access = n;
        addr_ready = 1'b1;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        // Scramble config so any late sampling would corrupt the stream.
        mode       = 2'($urandom);
        base_addr  = $urandom;
        stride     = $urandom;
        ws_size    = 16'($urandom);
        num_access = 16'($urandom);
        got = 0;
        cyc = 0;
        while (got < int'(n) && cyc < 500) begin
            if (stall_left > 0 && got == stall_at && addr_valid) begin
                addr_ready = 1'b0;
                stall_left--;
                chk("hold_valid", 32'(addr_valid), 32'd1);
                chk("hold_addr", address, exp_q.size() > 0 ? exp_q[0] : 32'hx);
                chk("hold_issued", 32'(issued), 32'(got));
            end else begin
                addr_ready = 1'b1;
            end
            if (addr_valid && addr_ready) begin
                chk("busy_run", 32'(busy), 32'd1);
                chk("issued_run", 32'(issued), 32'(got));
                if (use_model) chk("addr", address, exp_q.pop_front());
                if (m == 2'd2) chk("addr_align", 32'(address[1:0]), 32'd0);
                obs_q.push_back(address);
                got++;
            end
            tick();
            cyc++;
        end
        addr_ready = 1'b1;
        if (got < int'(n)) chk("timeout", 32'(got), 32'(n));
        if (stalls == 0) chk("rate", 32'(cyc), 32'(n));
        chk("done", 32'(done), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("valid_end", 32'(addr_valid), 32'd0);
        chk("issued_end", 32'(issued), 32'(n));
        tick();
        chk("done_pulse", 32'(done), 32'd0);
        chk("issued_hold", 32'(issued), 32'(n));
    endtask

    initial begin
        int diffs;
        rst_n      = 1'b0;
        start      = 1'b0;
        mode       = 2'd0;
        base_addr  = '0;
        stride     = '0;
        ws_size    = '0;
        num_access = '0;
        addr_ready = 1'b1;
        stall_at   = 0;
        stall_left = 0;
        tb_lfsr    = SEED;
        #3;
        chk("rst_addr", address, 32'd0);
        chk("rst_valid", 32'(addr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_issued", 32'(issued), 32'd0);
        apply_reset();

        // Sequential run
        do_run(2'd0, 32'h1000, 32'h10, 16'd0, 16'd4, 1'b1);

        // Backpressure on the second address for 3 cycles
        stall_at   = 1;
        stall_left = 3;
        do_run(2'd0, 32'h1000, 32'h10, 16'd0, 16'd4, 1'b1);
        stall_left = 0;

        // Looping working set, and a zero working set that repeats base
        do_run(2'd1, 32'h0, 32'h4, 16'd3, 16'd7, 1'b1);
        do_run(2'd1, 32'h200, 32'h4, 16'd0, 16'd3, 1'b1);

        // Address wrap, and reserved mode behaving as SEQ
        do_run(2'd0, 32'hFFFF_FFF0, 32'h10, 16'd0, 16'd2, 1'b1);
        do_run(2'd3, 32'h80, 32'h8, 16'd0, 16'd3, 1'b1);

        // Random: repeatable after reset, different back-to-back
        apply_reset();
        do_run(2'd2, 32'h4000_0000, 32'h0, 16'd0, 16'd6, 1'b1);
        ref_q = obs_q;
        apply_reset();
        do_run(2'd2, 32'h4000_0000, 32'h0, 16'd0, 16'd6, 1'b1);
        for (int i = 0; i < ref_q.size() && i < obs_q.size(); i++)
            chk("rand_repeat", obs_q[i], ref_q[i]);
        do_run(2'd2, 32'h4000_0000, 32'h0, 16'd0, 16'd6, 1'b0);
        diffs = 0;
        for (int i = 0; i < ref_q.size() && i < obs_q.size(); i++)
            if (obs_q[i] !== ref_q[i]) diffs++;
        chk("rand_differs", 32'(diffs != 0), 32'd1);

        // Zero-length run: done only
        do_run(2'd0, 32'h1000, 32'h10, 16'd0, 16'd0, 1'b1);

        // Reset mid-run drops valid/busy without a clock edge
        mode       = 2'd0;
        base_addr  = 32'h1000;
        stride     = 32'h10;
        num_access = 16'd4;
        addr_ready = 1'b1;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        tick();
        chk("mid_valid_pre", 32'(addr_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(addr_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_issued", 32'(issued), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        tb_lfsr = SEED;
        tick();
        do_run(2'd0, 32'h1000, 32'h10, 16'd0, 16'd4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
